link_train_ctrl: RTL and testbench

LINK_TRAIN_CTRL -- requirements
Module: link_train_ctrl

---
 rtl/link_train_pkg.sv | 18 +
 rtl/win_accum.sv | 33 +++
 rtl/link_train_ctrl.sv | 85 ++++++++
 tb/tb_link_train_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/link_train_pkg.sv
// link_train_pkg: shared state encoding, widths and parameter defaults for link training
package link_train_pkg;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_WAIT = 3'd2,
        S_MEAS = 3'd3,
        S_UP   = 3'd4,
        S_FAIL = 3'd5
    } state_t;
    localparam int ERR_W             = 6;
    localparam int WIN_W             = 16;
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_ALIGN_TIMEOUT = 8192;
    localparam int DEF_WIN_LEN       = 65536;
    localparam int DEF_ERR_LIMIT     = 0;
    localparam int DEF_MAX_RETRY     = 3;
endpackage

// File: rtl/win_accum.sv
// win_accum: window cycle counter with saturating error accumulation, restarting after each window
module win_accum
    import link_train_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [ERR_W-1:0] err_cnt,
    output logic [WIN_W-1:0] total,
    output logic             done
);
    localparam int CW = $clog2(WIN_LEN);
    logic [CW-1:0]    cnt;
    logic [WIN_W-1:0] acc;
    logic [WIN_W:0]   sum;
    always_comb begin
        sum   = {1'b0, acc} + (WIN_W + 1)'(err_cnt);
        total = sum[WIN_W] ? '1 : sum[WIN_W-1:0];
        done  = enable && !clear && cnt == CW'(WIN_LEN - 1);
    end
    always_ff @(posedge clk) begin
        if (reset || clear || done) begin
            acc <= '0;
            cnt <= '0;
        end else if (enable) begin
            acc <= total;
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/link_train_ctrl.sv
// link_train_ctrl: datapath reset, alignment wait and PRBS error-window link training with retries
module link_train_ctrl
    import link_train_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int ALIGN_TIMEOUT = DEF_ALIGN_TIMEOUT,
    parameter int WIN_LEN       = DEF_WIN_LEN,
    parameter int ERR_LIMIT     = DEF_ERR_LIMIT,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             aligned,
    input  logic [ERR_W-1:0] err_cnt,
    output logic             dp_reset,
    output logic             link_up,
    output logic             train_fail,
    output logic [2:0]       state,
    output logic [1:0]       retry_cnt,
    output logic [WIN_W-1:0] win_err,
    output logic             win_done
);
    localparam int TMAX = RST_CYCLES > ALIGN_TIMEOUT ? RST_CYCLES : ALIGN_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    state_t           st, nxt;
    logic [TW-1:0]    timer;
    logic             in_win, w_done, retry, fail_now, start_ok;
    logic [WIN_W-1:0] w_total;
    assign in_win   = st == S_MEAS || st == S_UP;
    assign start_ok = (st == S_IDLE || st == S_FAIL) && start;
    assign fail_now = ({1'b0, retry_cnt} + 3'd1) == 3'(MAX_RETRY);
    win_accum #(.WIN_LEN(WIN_LEN)) u_win (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_win || !aligned),
        .enable  (in_win),
        .err_cnt (err_cnt),
        .total   (w_total),
        .done    (w_done)
    );
    always_ff @(posedge clk) begin
        if (reset) st <= S_IDLE;
        else       st <= nxt;
    end
    always_comb begin
        nxt   = st;
        retry = 1'b0;
        case (st)
            S_IDLE, S_FAIL: nxt = start ? S_RST : st;
            S_RST:  nxt = timer == TW'(RST_CYCLES - 1) ? S_WAIT : S_RST;
            S_WAIT: begin
                nxt   = aligned ? S_MEAS : S_WAIT;
                retry = !aligned && timer == TW'(ALIGN_TIMEOUT - 1);
            end
            S_MEAS: begin
                nxt   = w_done ? S_UP : S_MEAS;
                retry = !aligned || (w_done && w_total > WIN_W'(ERR_LIMIT));
            end
            S_UP:   retry = !aligned || (w_done && w_total > WIN_W'(ERR_LIMIT));
            default: nxt = S_IDLE;
        endcase
        if (retry) nxt = fail_now ? S_FAIL : S_RST;
    end
    always_comb begin
        dp_reset   = st == S_IDLE || st == S_RST || st == S_FAIL;
        link_up    = st == S_UP;
        train_fail = st == S_FAIL;
        state      = st;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= '0;
            retry_cnt <= '0;
            win_err   <= '0;
            win_done  <= 1'b0;
        end else begin
            timer     <= nxt != st ? '0 : timer + TW'(1);
            retry_cnt <= start_ok || (st == S_MEAS && nxt == S_UP) ? 2'd0 :
                         retry && !fail_now ? retry_cnt + 2'd1 : retry_cnt;
            win_done  <= w_done;
            if (w_done) win_err <= w_total;
        end
    end
endmodule

// File: tb/tb_link_train_ctrl.sv
// tb_link_train_ctrl: directed link-training sequence with hand-computed expectations
module tb_link_train_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, aligned;
    logic [5:0]  err_cnt;
    logic        dp_reset, link_up, train_fail, win_done;
    logic [2:0]  state;
    logic [1:0]  retry_cnt;
    logic [15:0] win_err;
    logic        s_dp_reset, s_link_up, s_train_fail, s_win_done;
    logic [2:0]  s_state;
    logic [1:0]  s_retry_cnt;
    logic [15:0] s_win_err;
    int compared = 0;
    int mismatched = 0;
    always #5 clk = ~clk;
    link_train_ctrl #(.RST_CYCLES(4), .ALIGN_TIMEOUT(100), .WIN_LEN(64), .ERR_LIMIT(0), .MAX_RETRY(3)) dut (
        .clk(clk), .reset(reset), .start(start), .aligned(aligned), .err_cnt(err_cnt),
        .dp_reset(dp_reset), .link_up(link_up), .train_fail(train_fail), .state(state),
        .retry_cnt(retry_cnt), .win_err(win_err), .win_done(win_done)
    );
    link_train_ctrl #(.RST_CYCLES(4), .ALIGN_TIMEOUT(100), .WIN_LEN(2048), .ERR_LIMIT(0), .MAX_RETRY(3)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .aligned(aligned), .err_cnt(err_cnt),
        .dp_reset(s_dp_reset), .link_up(s_link_up), .train_fail(s_train_fail), .state(s_state),
        .retry_cnt(s_retry_cnt), .win_err(s_win_err), .win_done(s_win_done)
    );
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        reset = 1'b1; start = 1'b0; aligned = 1'b0; err_cnt = '0;
        step(3);
        chk("rst_state", state, 0);
        chk("rst_dp_reset", dp_reset, 1);
        chk("rst_link_up", link_up, 0);
        chk("rst_train_fail", train_fail, 0);
        chk("rst_retry", retry_cnt, 0);
        chk("rst_win_err", win_err, 0);
        chk("rst_win_done", win_done, 0);
        reset = 1'b0;
        step(1);
        chk("idle_hold", state, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("clean_rst", state, 1);
        chk("clean_dp_rst_hi", dp_reset, 1);
        step(3);
        chk("clean_rst_last", state, 1);
        step(1);
        chk("clean_wait", state, 2);
        chk("clean_dp_rst_lo", dp_reset, 0);
        step(4);
        aligned = 1'b1;
        step(1);
        chk("clean_meas", state, 3);
        step(63);
        chk("clean_meas_last", state, 3);
        chk("clean_no_done", win_done, 0);
        step(1);
        chk("clean_up", state, 4);
        chk("clean_link_up", link_up, 1);
        chk("clean_done", win_done, 1);
        chk("clean_win_err", win_err, 0);
        chk("clean_retry", retry_cnt, 0);
        step(1);
        chk("clean_done_pulse", win_done, 0);
        step(62);
        chk("lock_pre", state, 4);
        aligned = 1'b0; err_cnt = 6'd5;
        step(1);
        aligned = 1'b1; err_cnt = '0;
        chk("lock_state", state, 1);
        chk("lock_no_done", win_done, 0);
        chk("lock_link_up", link_up, 0);
        chk("lock_retry", retry_cnt, 1);
        chk("lock_win_err", win_err, 0);
        step(5);
        chk("wf_meas", state, 3);
        err_cnt = 6'd1;
        step(1);
        err_cnt = '0;
        step(62);
        chk("wf_meas_last", state, 3);
        chk("wf_no_done", win_done, 0);
        step(1);
        chk("wf_done", win_done, 1);
        chk("wf_win_err", win_err, 1);
        chk("wf_state", state, 1);
        chk("wf_retry", retry_cnt, 2);
        step(1);
        chk("wf_done_pulse", win_done, 0);
        chk("wf_win_err_hold", win_err, 1);
        step(4);
        chk("mr_meas", state, 3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mr_state", state, 0);
        chk("mr_win_err", win_err, 0);
        chk("mr_dp_reset", dp_reset, 1);
        chk("mr_retry", retry_cnt, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("re_rst", state, 1);
        step(5);
        chk("re_meas", state, 3);
        step(64);
        chk("re_up", state, 4);
        chk("re_win_err", win_err, 0);
        chk("re_retry", retry_cnt, 0);
        reset = 1'b1; aligned = 1'b0;
        step(1);
        reset = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("na_rst", state, 1);
        for (int k = 1; k <= 2; k++) begin
            step(103);
            chk("na_wait", state, 2);
            step(1);
            chk("na_retry_rst", state, 1);
            chk("na_retry_cnt", retry_cnt, k);
        end
        step(103);
        chk("na_wait_last", state, 2);
        step(1);
        chk("na_fail", state, 5);
        chk("na_train_fail", train_fail, 1);
        chk("na_dp_reset", dp_reset, 1);
        chk("na_retry", retry_cnt, 2);
        chk("na_link_up", link_up, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("ff_rst", state, 1);
        chk("ff_retry", retry_cnt, 0);
        chk("ff_train_fail", train_fail, 0);
        step(4);
        chk("ff_wait", state, 2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("ign_start", state, 2);
        step(98);
        chk("co_wait", state, 2);
        aligned = 1'b1;
        step(1);
        chk("co_meas", state, 3);
        chk("sat_meas", s_state, 3);
        err_cnt = 6'd63;
        step(64);
        chk("err_win_err", win_err, 16'h0FC0);
        chk("err_done", win_done, 1);
        chk("err_state", state, 1);
        chk("err_retry", retry_cnt, 1);
        chk("sat_still_meas", s_state, 3);
        step(1984);
        chk("sat_win_err", s_win_err, 16'hFFFF);
        chk("sat_done", s_win_done, 1);
        chk("sat_state", s_state, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
